// File: rtl/maxpool_pair.sv
// maxpool_pair: 1-D max-pool (size 2, stride 2) per channel over pairs of input beats, repacked to the input lane count.
//   clk, rst       : clock, synchronous active-high reset
//   vld_in/data_in : input beat, THROUGHPUT lanes of NO_CH*BW bits (lane THROUGHPUT-1 earliest)
//   vld_out/data_out/last_out : registered pooled beat, same lane order; last_out marks the final beat of a frame
//   MAXPOOL_PAIR_OUT_REG_EN   : when defined, adds a second output register stage (latency 2)
module maxpool_pair #(
  parameter int NO_CH = 8,
  parameter int BW = 1,
  parameter int LOG2_IMG_SIZE = 7,
  parameter int THROUGHPUT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  input  logic [NO_CH*BW-1:0]   data_in [THROUGHPUT],
  output logic                  vld_out,
  output logic [NO_CH*BW-1:0]   data_out [THROUGHPUT],
  output logic                  last_out
);
  localparam int W = NO_CH * BW;
  localparam int HALF = THROUGHPUT > 1 ? THROUGHPUT / 2 : 1;
  localparam int CW = LOG2_IMG_SIZE - $clog2(THROUGHPUT);

  function automatic logic [W-1:0] vmax(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < NO_CH; c++)
      r[c*BW +: BW] = x[c*BW +: BW] > y[c*BW +: BW] ? x[c*BW +: BW] : y[c*BW +: BW];
    return r;
  endfunction

  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hold_q [HALF];
  logic [W-1:0]  hold_d [HALF];
  logic [W-1:0]  pool [HALF];
  logic [W-1:0]  pair [THROUGHPUT];
  logic          vld_q, vld_d, last_q, last_d;
  logic [W-1:0]  out_q [THROUGHPUT];
  logic [W-1:0]  out_d [THROUGHPUT];

  // With one lane the pair is pooled across beats, so A is held raw.
  if (THROUGHPUT == 1) begin : g_one
    assign pool[0] = data_in[0];
    assign pair[0] = vmax(hold_q[0], pool[0]);
  end else begin : g_multi
    for (genvar k = 0; k < HALF; k++) begin : g_lane
      assign pool[k] = vmax(data_in[2*k+1], data_in[2*k]);
      assign pair[HALF+k] = hold_q[k];
      assign pair[k] = pool[k];
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    out_d = out_q;
    vld_d = vld_in & phase_q;
    last_d = vld_in & phase_q & (&cnt_q);
    if (vld_in) begin
      phase_d = ~phase_q;
      cnt_d = cnt_q + 1'b1;
      if (!phase_q) hold_d = pool;
      else out_d = pair;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      cnt_q <= '0;
      hold_q <= '{default: '0};
      vld_q <= 1'b0;
      last_q <= 1'b0;
      out_q <= '{default: '0};
    end else begin
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      vld_q <= vld_d;
      last_q <= last_d;
      out_q <= out_d;
    end
  end

`ifdef MAXPOOL_PAIR_OUT_REG_EN
  logic         vld2_q, last2_q;
  logic [W-1:0] out2_q [THROUGHPUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_q <= 1'b0;
      last2_q <= 1'b0;
      out2_q <= '{default: '0};
    end else begin
      vld2_q <= vld_q;
      last2_q <= last_q;
      out2_q <= out_q;
    end
  end

  assign vld_out = vld2_q;
  assign last_out = last2_q;
  assign data_out = out2_q;
`else
  assign vld_out = vld_q;
  assign last_out = last_q;
  assign data_out = out_q;
`endif
endmodule

// File: tb/tb_maxpool_pair.sv
// tb_maxpool_pair: directed checks of maxpool_pair across four lane/channel configurations.
module tb_maxpool_pair;
`ifdef MAXPOOL_PAIR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_vld, a_vo, a_lo;
  logic [7:0] a_din [1];
  logic [7:0] a_do [1];
  logic b_vld, b_vo, b_lo;
  logic [7:0] b_din [1];
  logic [7:0] b_do [1];
  logic c_vld, c_vo, c_lo;
  logic [7:0] c_din [2];
  logic [7:0] c_do [2];
  logic d_vld, d_vo, d_lo;
  logic [7:0] d_din [4];
  logic [7:0] d_do [4];

  maxpool_pair #(.NO_CH(8), .BW(1), .LOG2_IMG_SIZE(7), .THROUGHPUT(1)) u_a (
    .clk(clk), .rst(rst), .vld_in(a_vld), .data_in(a_din),
    .vld_out(a_vo), .data_out(a_do), .last_out(a_lo));
  maxpool_pair #(.NO_CH(1), .BW(8), .LOG2_IMG_SIZE(7), .THROUGHPUT(1)) u_b (
    .clk(clk), .rst(rst), .vld_in(b_vld), .data_in(b_din),
    .vld_out(b_vo), .data_out(b_do), .last_out(b_lo));
  maxpool_pair #(.NO_CH(1), .BW(8), .LOG2_IMG_SIZE(7), .THROUGHPUT(2)) u_c (
    .clk(clk), .rst(rst), .vld_in(c_vld), .data_in(c_din),
    .vld_out(c_vo), .data_out(c_do), .last_out(c_lo));
  maxpool_pair #(.NO_CH(2), .BW(4), .LOG2_IMG_SIZE(7), .THROUGHPUT(4)) u_d (
    .clk(clk), .rst(rst), .vld_in(d_vld), .data_in(d_din),
    .vld_out(d_vo), .data_out(d_do), .last_out(d_lo));

  logic [31:0] aq[$], bq[$], cq[$], dq[$];
  logic al[$], bl[$], cl[$], dl[$];
  int ac[$], bc[$];
  int dc[$];

  always @(negedge clk) begin
    if (a_vo) begin aq.push_back({24'h0, a_do[0]}); al.push_back(a_lo); ac.push_back(cyc); end
    if (b_vo) begin bq.push_back({24'h0, b_do[0]}); bl.push_back(b_lo); bc.push_back(cyc); end
    if (c_vo) begin cq.push_back({16'h0, c_do[1], c_do[0]}); cl.push_back(c_lo); end
    if (d_vo) begin dq.push_back({d_do[3], d_do[2], d_do[1], d_do[0]}); dl.push_back(d_lo); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0; d_vld = 1'b0;
  endtask

  task automatic beat(input int sel, input logic [31:0] v);
    @(negedge clk);
    quiet();
    case (sel)
      0: begin a_vld = 1'b1; a_din[0] = v[7:0]; end
      1: begin b_vld = 1'b1; b_din[0] = v[7:0]; end
      2: begin c_vld = 1'b1; c_din[1] = v[15:8]; c_din[0] = v[7:0]; end
      default: begin d_vld = 1'b1; d_din[3] = v[31:24]; d_din[2] = v[23:16]; d_din[1] = v[15:8]; d_din[0] = v[7:0]; end
    endcase
    dc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      quiet();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    quiet();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    aq.delete(); bq.delete(); cq.delete(); dq.delete();
    al.delete(); bl.delete(); cl.delete(); dl.delete();
    ac.delete(); bc.delete(); dc.delete();
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    a_din[0] = '0; b_din[0] = '0;
    c_din = '{default: '0};
    d_din = '{default: '0};
    repeat (3) @(negedge clk);
    check("rst_a_vld", {31'h0, a_vo}, 32'h0);
    check("rst_a_last", {31'h0, a_lo}, 32'h0);
    check("rst_a_data", {24'h0, a_do[0]}, 32'h0);
    check("rst_c_data", {16'h0, c_do[1], c_do[0]}, 32'h0);
    check("rst_d_data", {d_do[3], d_do[2], d_do[1], d_do[0]}, 32'h0);
    check("rst_d_vld", {31'h0, d_vo}, 32'h0);
    do_reset();

    beat(1, 50);
    do_reset();
    beat(1, 6);
    beat(1, 2);
    idle(4);
    check("rstA_count", bq.size(), 1);
    check("rstA_val", bq[0], 6);
    bq.delete(); bl.delete();
    beat(1, 5); beat(1, 9); beat(1, 200); beat(1, 3);
    idle(4);
    check("b8_count", bq.size(), 2);
    check("b8_val0", bq[0], 9);
    check("b8_val1", bq[1], 200);
    check("b8_last", {31'h0, bl[1]}, 32'h0);

    do_reset();
    for (int i = 0; i < 128; i++) beat(0, i);
    idle(4);
    check("a_count", aq.size(), 64);
    for (int j = 0; j < 64; j++) begin
      check($sformatf("a_val%0d", j), aq[j], 2 * j + 1);
      check($sformatf("a_last%0d", j), {31'h0, al[j]}, {31'h0, j == 63});
      check($sformatf("a_cyc%0d", j), ac[j], dc[2 * j + 1] + LAT);
    end

    do_reset();
    for (int i = 0; i < 128; i++) begin
      beat(1, i);
      if (i == 10) idle(5);
    end
    idle(31);
    check("bg_count", bq.size(), 64);
    for (int j = 0; j < 64; j++) begin
      check($sformatf("bg_val%0d", j), bq[j], 2 * j + 1);
      check($sformatf("bg_last%0d", j), {31'h0, bl[j]}, {31'h0, j == 63});
      check($sformatf("bg_cyc%0d", j), bc[j], dc[2 * j + 1] + LAT);
    end

    do_reset();
    beat(2, 32'h0407);
    beat(2, 32'h0102);
    idle(4);
    check("c_pair_count", cq.size(), 1);
    check("c_pair_val", cq[0], 32'h0702);
    do_reset();
    for (int b = 0; b < 64; b++) beat(2, {16'h0, 8'(2 * b), 8'(2 * b + 1)});
    idle(4);
    check("c_count", cq.size(), 32);
    for (int j = 0; j < 32; j++) begin
      check($sformatf("c_val%0d", j), cq[j], {16'h0, 8'(4 * j + 1), 8'(4 * j + 3)});
      check($sformatf("c_last%0d", j), {31'h0, cl[j]}, {31'h0, j == 31});
    end

    do_reset();
    beat(3, 32'h3C912552);
    beat(3, 32'h0FF07768);
    for (int i = 0; i < 30; i++) beat(3, 32'h0);
    idle(4);
    check("d_count", dq.size(), 16);
    check("d_val0", dq[0], 32'h9C55FF78);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) check($sformatf("d_val%0d", j), dq[j], 32'h0);
      check($sformatf("d_last%0d", j), {31'h0, dl[j]}, {31'h0, j == 15});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
